// File: rtl/arb_dds_phase_acc.sv
// DDS phase accumulator and waveform-RAM address generator.
// Continuous or triggered-burst stepping; frequency/phase changes land on a waveform wrap.
module arb_dds_phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              BurstMode,
  input  logic              Trigger,
  input  logic [CNT_W-1:0]  BurstCount,
  input  logic [ACC_W-1:0]  FreqWord,
  input  logic [ADDR_W-1:0] PhaseOff,
  input  logic              CfgLoad,
  output logic              CfgAck,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrValid,
  output logic              Wrap,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, RUN, ARMED, BURST} state_t;

  state_t            state, state_nx;
  logic [ACC_W-1:0]  acc, acc_nx, sum, freq_sh, freq_act;
  logic [ADDR_W-1:0] phase_sh, phase_act;
  logic [CNT_W-1:0]  bcnt, bcnt_nx, bcnt_inc;
  logic              carry, trig_q, trig_rise, running, valid_nx, load_act;

  assign {carry, sum} = {1'b0, acc} + {1'b0, freq_act};
  assign trig_rise    = Trigger & ~trig_q;
  assign running      = (state == RUN) || (state == BURST);
  assign bcnt_inc     = bcnt + CNT_W'(1);
  assign valid_nx     = running & Enable;
  // Increment may only change on a waveform boundary while stepping, so the
  // output never sees a partial cycle at two different rates.
  assign load_act     = ~running | carry;
  assign Busy         = running;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    bcnt_nx  = bcnt;
    case (state)
      IDLE:  if (Enable) state_nx = BurstMode ? ARMED : RUN;
      RUN:   acc_nx = sum;
      ARMED: if (trig_rise) begin
        state_nx = BURST;
        bcnt_nx  = '0;
      end
      BURST: begin
        acc_nx = sum;
        if (carry) begin
          bcnt_nx = bcnt_inc;
          if (BurstCount != '0 && bcnt_inc == BurstCount) begin
            state_nx = ARMED;
            acc_nx   = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!Enable) begin
      state_nx = IDLE;
      acc_nx   = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      acc       <= '0;
      bcnt      <= '0;
      trig_q    <= 1'b0;
      freq_sh   <= '0;
      phase_sh  <= '0;
      freq_act  <= '0;
      phase_act <= '0;
      CfgAck    <= 1'b0;
      Addr      <= '0;
      AddrValid <= 1'b0;
      Wrap      <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      bcnt   <= bcnt_nx;
      trig_q <= Trigger;
      CfgAck <= CfgLoad;
      if (CfgLoad) begin
        freq_sh  <= FreqWord;
        phase_sh <= PhaseOff;
      end
      // Reads the pre-load shadow, so a load coinciding with a wrap waits a cycle.
      if (load_act) begin
        freq_act  <= freq_sh;
        phase_act <= phase_sh;
      end
      // Addr is parked at 0 whenever it is not a live sample.
      Addr      <= valid_nx ? sum[ACC_W-1 -: ADDR_W] + phase_act : '0;
      AddrValid <= valid_nx;
      Wrap      <= valid_nx & carry;
    end
  end

endmodule

// File: tb/tb_arb_dds_phase_acc.sv
// Scoreboard bench for arb_dds_phase_acc (ACC_W=8, ADDR_W=4): continuous, config
// double-buffering, bursts, Enable override and asynchronous reset.
module tb_arb_dds_phase_acc;
  localparam int ACC_W = 8, ADDR_W = 4, CNT_W = 16;

  logic              Clock = 1'b0, Reset = 1'b1;
  logic              Enable = 1'b0, BurstMode = 1'b0, Trigger = 1'b0, CfgLoad = 1'b0;
  logic [CNT_W-1:0]  BurstCount = '0;
  logic [ACC_W-1:0]  FreqWord = '0;
  logic [ADDR_W-1:0] PhaseOff = '0;
  logic              CfgAck, AddrValid, Wrap, Busy;
  logic [ADDR_W-1:0] Addr;

  typedef struct {
    int addr;
    bit valid, wrap, busy, ack;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, mcyc = 0;

  always #5 Clock = ~Clock;

  arb_dds_phase_acc #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .BurstMode(BurstMode),
    .Trigger(Trigger), .BurstCount(BurstCount), .FreqWord(FreqWord),
    .PhaseOff(PhaseOff), .CfgLoad(CfgLoad), .CfgAck(CfgAck), .Addr(Addr),
    .AddrValid(AddrValid), .Wrap(Wrap), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, expv);
    end
  endtask

  // Queue expected outputs for the coming edge, then advance to the next negedge.
  task automatic cyc(input int a, input bit v, input bit w, input bit b, input bit k = 1'b0);
    exp_t e;
    e.addr = a; e.valid = v; e.wrap = w; e.busy = b; e.ack = k;
    sb.push_back(e);
    @(negedge Clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  32'(Addr), 0);
    chk({tag, "_valid"}, 32'(AddrValid), 0);
    chk({tag, "_wrap"},  32'(Wrap), 0);
    chk({tag, "_busy"},  32'(Busy), 0);
    chk({tag, "_ack"},   32'(CfgAck), 0);
  endtask

  task automatic burst();
    Trigger = 1'b1; cyc(0, 0, 0, 1);
    Trigger = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      Trigger = (k == 6);  // edge inside BURST must be ignored
      cyc((4 * k) % 16, 1, (k % 4) == 0, k != 12);
    end
    Trigger = 1'b0;
    cyc(0, 0, 0, 0);
  endtask

  always @(posedge Clock) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      mcyc++;
      chk($sformatf("c%0d_addr", mcyc),  32'(Addr),      32'(e.addr));
      chk($sformatf("c%0d_valid", mcyc), 32'(AddrValid), 32'(e.valid));
      chk($sformatf("c%0d_wrap", mcyc),  32'(Wrap),      32'(e.wrap));
      chk($sformatf("c%0d_busy", mcyc),  32'(Busy),      32'(e.busy));
      chk($sformatf("c%0d_ack", mcyc),   32'(CfgAck),    32'(e.ack));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #3 chk_zero("reset");
    @(negedge Clock); Reset = 1'b0;

    // Continuous, step 1 address per clock
    FreqWord = 8'h10; PhaseOff = 4'd0; CfgLoad = 1'b1; cyc(0, 0, 0, 0, 1);
    CfgLoad = 1'b0; cyc(0, 0, 0, 0);
    Enable = 1'b1; cyc(0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) cyc(k % 16, 1, k == 16, 1);

    // Phase offset 3 loaded mid-cycle, takes effect after the wrap
    PhaseOff = 4'd3;
    for (int k = 1; k <= 16; k++) begin
      CfgLoad = (k == 1);
      cyc(k % 16, 1, k == 16, 1, k == 1);
    end
    CfgLoad = 1'b0;
    for (int k = 1; k <= 16; k++) cyc((k + 3) % 16, 1, k == 16, 1);

    // Frequency 0x20 loaded mid-cycle: step stays 1 until wrap
    for (int k = 1; k <= 16; k++) begin
      CfgLoad = (k == 5);
      if (k == 5) FreqWord = 8'h20;
      cyc((k + 3) % 16, 1, k == 16, 1, k == 5);
    end
    // Load coincident with wrap: old shadow (0x20) applied, 0x10 waits a full cycle
    for (int k = 1; k <= 8; k++) begin
      CfgLoad = (k == 8);
      if (k == 8) FreqWord = 8'h10;
      cyc((2 * k + 3) % 16, 1, k == 8, 1, k == 8);
    end
    CfgLoad = 1'b0;
    for (int k = 1; k <= 8; k++) cyc((2 * k + 3) % 16, 1, k == 8, 1);
    cyc(4, 1, 0, 1);
    Enable = 1'b0; cyc(0, 0, 0, 0);

    // Triggered bursts of 3 cycles at step 4
    FreqWord = 8'h40; PhaseOff = 4'd0; BurstCount = 16'd3; CfgLoad = 1'b1; cyc(0, 0, 0, 0, 1);
    CfgLoad = 1'b0; Enable = 1'b1; BurstMode = 1'b1; cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    burst();
    burst();

    // Enable drop coincident with a trigger edge mid-burst
    Trigger = 1'b1; cyc(0, 0, 0, 1);
    Trigger = 1'b0;
    for (int k = 1; k <= 5; k++) cyc((4 * k) % 16, 1, (k % 4) == 0, 1);
    Enable = 1'b0; Trigger = 1'b1; cyc(0, 0, 0, 0);
    Trigger = 1'b0; BurstMode = 1'b0; cyc(0, 0, 0, 0);

    // Asynchronous reset between edges while running
    Enable = 1'b1; cyc(0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) cyc(4 * k, 1, 0, 1);
    #2 Reset = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge Clock); Enable = 1'b0;
    @(negedge Clock); Reset = 1'b0;
    CfgLoad = 1'b1; cyc(0, 0, 0, 0, 1);
    CfgLoad = 1'b0; cyc(0, 0, 0, 0);
    Enable = 1'b1; cyc(0, 0, 0, 1);
    for (int k = 1; k <= 2; k++) cyc(4 * k, 1, 0, 1);
    Enable = 1'b0; cyc(0, 0, 0, 0);

    @(negedge Clock);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
